fll_loop_controller: RTL

- Sequences the frequency-locked loop by consuming the filtered band-edge error stream from the FLL loop filter and integrating it into the NCO frequency control word.
- Schedules the loop gain: a wide-bandwidth ACQUIRE state and a narrow TRACK state.
- Detects lock and loss of lock.
- Performs a coarse frequency sweep when acquisition times out. This covers LEO Doppler of ±80 kHz.
- Sits between the loop filter output and the NCO/mixer.

---
 rtl/fll_pkg.sv | 33 +++
 rtl/fll_lock_detector.sv | 64 ++++++
 rtl/fll_loop_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fll_pkg.sv
// rtl/fll_pkg.sv - FLL loop controller state encoding, default widths and saturating add
package fll_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        SWEEP   = 2'b10,
        TRACK   = 2'b11
    } fll_state_t;

    localparam int FLL_ERR_BITS  = 12;
    localparam int FLL_FREQ_BITS = 24;

    // Symmetric clamp to +/-(2^(bits-1)-1); operands arrive already sign-extended.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 bits
    );
        logic signed [63:0] lim;
        logic signed [63:0] sum;
        lim = (64'sd1 <<< (bits - 1)) - 64'sd1;
        sum = a + b;
        if (sum > lim) begin
            return lim;
        end
        if (sum < -lim) begin
            return -lim;
        end
        return sum;
    endfunction

endpackage

// File: rtl/fll_lock_detector.sv
// rtl/fll_lock_detector.sv - |err| threshold compare with lock/unlock run counters
module fll_lock_detector
    import fll_pkg::*;
#(
    parameter int ErrBits       = FLL_ERR_BITS,
    parameter int LockThreshold = 64,
    parameter int LockCount     = 256,
    parameter int UnlockCount   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      sample,
    input  logic signed [ErrBits-1:0] err,
    output logic                      lock_hit,
    output logic                      unlock_hit
);
    localparam int                 LW          = $clog2(LockCount + 1);
    localparam int                 UW          = $clog2(UnlockCount + 1);
    localparam logic [LW-1:0]      LOCK_LAST   = LW'(LockCount - 1);
    localparam logic [UW-1:0]      UNLOCK_LAST = UW'(UnlockCount - 1);
    localparam logic [ErrBits-1:0] THRESH      = ErrBits'(LockThreshold);
    localparam logic [ErrBits-1:0] MOST_NEG    = {1'b1, {(ErrBits-1){1'b0}}};

    logic [ErrBits-1:0] mag;
    logic               in_lock;
    logic [LW-1:0]      lock_cnt;
    logic [UW-1:0]      unlock_cnt;

    // The most negative code has no positive twin, so it folds onto the largest magnitude.
    always_comb begin
        if (err == MOST_NEG) begin
            mag = ~MOST_NEG;
        end else if (err[ErrBits-1]) begin
            mag = $unsigned(-err);
        end else begin
            mag = $unsigned(err);
        end
    end

    assign in_lock    = (mag <= THRESH);
    assign lock_hit   = sample && in_lock && (lock_cnt >= LOCK_LAST);
    assign unlock_hit = sample && !in_lock && (unlock_cnt >= UNLOCK_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lock_cnt   <= '0;
            unlock_cnt <= '0;
        end else if (sample) begin
            if (in_lock) begin
                if (lock_cnt != '1) begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
                unlock_cnt <= '0;
            end else begin
                lock_cnt <= '0;
                if (unlock_cnt != '1) begin
                    unlock_cnt <= unlock_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fll_loop_controller.sv
// rtl/fll_loop_controller.sv - FLL sequencer (gain schedule, lock, sweep); FLL_LOCK_STATS_EN adds lock_losses/sweep_steps
module fll_loop_controller
    import fll_pkg::*;
#(
    parameter int ErrBits       = FLL_ERR_BITS,
    parameter int FreqBits      = FLL_FREQ_BITS,
    parameter int AcqShift      = 8,
    parameter int TrackShift    = 3,
    parameter int LockThreshold = 64,
    parameter int LockCount     = 256,
    parameter int UnlockCount   = 32,
    parameter int AcqTimeout    = 65536,
    parameter int SweepStep     = 262144,
    parameter int SweepLimit    = 2097152
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic signed [ErrBits-1:0]  err,
    input  logic                       err_valid,
    output logic                       err_ready,
    output logic signed [FreqBits-1:0] freq_word,
    output logic                       freq_valid,
    input  logic                       freq_ready,
    output logic                       locked,
`ifdef FLL_LOCK_STATS_EN
    output logic [15:0]                lock_losses,
    output logic [15:0]                sweep_steps,
`endif
    output logic [1:0]                 state
);
    localparam int              TW       = $clog2(AcqTimeout + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(AcqTimeout - 1);
    localparam logic signed [63:0] LIM64 = 64'(SweepLimit);

    fll_state_t                 cur;
    fll_state_t                 nxt;
    logic signed [FreqBits-1:0] freq_nxt;
    logic signed [FreqBits-1:0] upd;
    logic                       fv_nxt;
    logic                       locked_nxt;
    logic                       clear;
    logic                       accept;
    logic                       lock_hit;
    logic                       unlock_hit;
    logic                       tmo_hit;
    logic [TW-1:0]              tmo_cnt;
    logic [TW-1:0]              tmo_nxt;
    logic signed [63:0]         err64;
    logic signed [63:0]         fw64;
    logic signed [63:0]         sw64;

    assign state     = cur;
    assign err_ready = enable && (cur == ACQUIRE || cur == TRACK) && (!freq_valid || freq_ready);
    assign accept    = err_valid && err_ready;
    assign tmo_hit   = accept && (tmo_cnt >= TMO_LAST);

    assign err64 = {{(64-ErrBits){err[ErrBits-1]}}, err};
    assign fw64  = {{(64-FreqBits){freq_word[FreqBits-1]}}, freq_word};
    assign upd   = FreqBits'(sat_add(fw64, (cur == TRACK) ? (err64 <<< TrackShift) : (err64 <<< AcqShift), FreqBits));
    assign sw64  = fw64 + 64'(SweepStep);

    fll_lock_detector #(
        .ErrBits       (ErrBits),
        .LockThreshold (LockThreshold),
        .LockCount     (LockCount),
        .UnlockCount   (UnlockCount)
    ) u_lock (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .sample     (accept),
        .err        (err),
        .lock_hit   (lock_hit),
        .unlock_hit (unlock_hit)
    );

    always_comb begin
        nxt        = cur;
        freq_nxt   = freq_word;
        fv_nxt     = freq_valid && !freq_ready;
        locked_nxt = locked;
        tmo_nxt    = tmo_cnt;
        clear      = 1'b0;
        if (!enable) begin
            nxt        = IDLE;
            fv_nxt     = 1'b0;
            locked_nxt = 1'b0;
            tmo_nxt    = '0;
            clear      = 1'b1;
        end else begin
            if (accept) begin
                freq_nxt = upd;
                fv_nxt   = 1'b1;
                if (tmo_cnt != '1) begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            case (cur)
                IDLE: begin
                    nxt     = ACQUIRE;
                    tmo_nxt = '0;
                    clear   = 1'b1;
                end
                ACQUIRE: begin
                    // Lock takes priority over a timeout landing on the same sample.
                    if (lock_hit) begin
                        nxt        = TRACK;
                        locked_nxt = 1'b1;
                        tmo_nxt    = '0;
                        clear      = 1'b1;
                    end else if (tmo_hit) begin
                        nxt = SWEEP;
                    end
                end
                SWEEP: begin
                    if (!freq_valid || freq_ready) begin
                        freq_nxt = (sw64 > LIM64) ? FreqBits'(-LIM64) : FreqBits'(sw64);
                        fv_nxt   = 1'b1;
                        tmo_nxt  = '0;
                        clear    = 1'b1;
                        nxt      = ACQUIRE;
                    end
                end
                TRACK: begin
                    if (unlock_hit) begin
                        nxt        = ACQUIRE;
                        locked_nxt = 1'b0;
                        tmo_nxt    = '0;
                        clear      = 1'b1;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= IDLE;
            freq_word  <= '0;
            freq_valid <= 1'b0;
            locked     <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            cur        <= nxt;
            freq_word  <= freq_nxt;
            freq_valid <= fv_nxt;
            locked     <= locked_nxt;
            tmo_cnt    <= tmo_nxt;
        end
    end

`ifdef FLL_LOCK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_losses <= '0;
            sweep_steps <= '0;
        end else begin
            if (cur == TRACK && nxt == ACQUIRE && lock_losses != 16'hFFFF) begin
                lock_losses <= lock_losses + 16'd1;
            end
            if (cur != SWEEP && nxt == SWEEP && sweep_steps != 16'hFFFF) begin
                sweep_steps <= sweep_steps + 16'd1;
            end
        end
    end
`endif

endmodule
